// File: rtl/relais_seq.sv
// Break-before-make sequencer for two relay channels (A, B).
// Opens the active relay, waits, closes the target, waits for settling, then holds off new requests.
module relais_seq #(
    parameter int BREAK_CYC  = 4,
    parameter int SETTLE_CYC = 8,
    parameter int MIN_HOLD   = 16,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_tgt,
    output logic       drv_a,
    output logic       drv_b,
    output logic [1:0] conn,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_BREAK = 3'd1,
        ST_MAKE  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ON    = 3'd4
    } state_t;

    localparam logic [CW-1:0] BREAK_LD  = CW'(BREAK_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(MIN_HOLD - 1);
    localparam logic [CW-1:0] CNT_ZERO  = '0;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    tgt_q, tgt_d;
    logic [1:0]    conn_q, conn_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          drv_a_q, drv_a_d;
    logic          drv_b_q, drv_b_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          accept_s;
    logic          drive_on_s;

    assign accept_s = req_valid && ready_q;

    // State and output registers; reset opens both drives on the very next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= CNT_ZERO;
            tgt_q   <= 2'b00;
            conn_q  <= 2'b00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            drv_a_q <= 1'b0;
            drv_b_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            conn_q  <= conn_d;
            done_q  <= done_d;
            err_q   <= err_d;
            drv_a_q <= drv_a_d;
            drv_b_q <= drv_b_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // Next-state, counter and event-pulse logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        conn_d  = conn_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_OFF, ST_ON: begin
                if (accept_s) begin
                    if (req_tgt == 2'b11) begin
                        err_d = 1'b1;
                    end else if (req_tgt == conn_q) begin
                        done_d = 1'b1;
                    end else if (state_q == ST_ON) begin
                        state_d = ST_BREAK;
                        cnt_d   = BREAK_LD;
                        tgt_d   = req_tgt;
                    end else begin
                        state_d = ST_MAKE;
                        cnt_d   = SETTLE_LD;
                        tgt_d   = req_tgt;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_BREAK: begin
                if (cnt_q == CNT_ZERO) begin
                    if (tgt_q == 2'b00) begin
                        state_d = ST_OFF;
                        conn_d  = 2'b00;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_MAKE;
                        cnt_d   = SETTLE_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_MAKE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_HOLD;
                    conn_d  = tgt_q;
                    done_d  = 1'b1;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_ON;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = CNT_ZERO;
                tgt_d   = 2'b00;
                conn_d  = 2'b00;
            end
        endcase
    end

    // Drives follow the next state, so only one channel can ever be selected.
    always_comb begin
        drive_on_s = 1'b0;
        busy_d     = 1'b0;
        ready_d    = 1'b0;
        case (state_d)
            ST_OFF:   ready_d = 1'b1;
            ST_BREAK: busy_d  = 1'b1;
            ST_MAKE: begin
                busy_d     = 1'b1;
                drive_on_s = 1'b1;
            end
            ST_HOLD: begin
                busy_d     = 1'b1;
                drive_on_s = 1'b1;
            end
            ST_ON: begin
                ready_d    = 1'b1;
                drive_on_s = 1'b1;
            end
            default: ready_d = 1'b0;
        endcase
        drv_a_d = drive_on_s && (tgt_d == 2'b01);
        drv_b_d = drive_on_s && (tgt_d == 2'b10);
    end

    assign req_ready = ready_q;
    assign drv_a     = drv_a_q;
    assign drv_b     = drv_b_q;
    assign conn      = conn_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_relais_seq.sv
// Directed bench for relais_seq with default timing parameters.
module tb_relais_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_tgt;
    logic       drv_a;
    logic       drv_b;
    logic [1:0] conn;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;
    logic mon_en = 1'b0;

    relais_seq dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tgt   (req_tgt),
        .drv_a     (drv_a),
        .drv_b     (drv_b),
        .conn      (conn),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one active edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both relays must never be commanded closed together.
    always @(negedge clk) begin
        if (mon_en) check_eq("no_overlap", {31'd0, drv_a & drv_b}, 32'd0);
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_tgt   = 2'b00;
        tick();
        tick();
        rst    = 1'b0;
        mon_en = 1'b1;
        check_eq("rst_drv_a", drv_a, 1'b0);
        check_eq("rst_drv_b", drv_b, 1'b0);
        check_eq("rst_conn",  conn,  2'b00);
        check_eq("rst_busy",  busy,  1'b0);
        check_eq("rst_done",  done,  1'b0);
        check_eq("rst_err",   err,   1'b0);
        check_eq("rst_ready", req_ready, 1'b1);

        // OFF -> A
        req_valid = 1'b1; req_tgt = 2'b01;
        tick();
        req_valid = 1'b0;
        check_eq("offa_drv_a_E", drv_a, 1'b1);
        check_eq("offa_busy_E",  busy,  1'b1);
        check_eq("offa_ready_E", req_ready, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            tick();
            check_eq("offa_drv_a", drv_a, 1'b1);
            check_eq("offa_drv_b", drv_b, 1'b0);
            check_eq("offa_done",  done,  (k == 8) ? 1'b1 : 1'b0);
            check_eq("offa_conn",  conn,  (k >= 8) ? 2'b01 : 2'b00);
            check_eq("offa_ready", req_ready, (k >= 24) ? 1'b1 : 1'b0);
        end
        check_eq("offa_busy_end", busy, 1'b0);

        // Illegal target in ON A
        req_valid = 1'b1; req_tgt = 2'b11;
        tick();
        req_valid = 1'b0;
        check_eq("ill_err",   err,   1'b1);
        check_eq("ill_drv_a", drv_a, 1'b1);
        check_eq("ill_conn",  conn,  2'b01);
        check_eq("ill_done",  done,  1'b0);
        check_eq("ill_ready", req_ready, 1'b1);
        tick();
        check_eq("ill_err_clr", err,  1'b0);
        check_eq("ill_done2",   done, 1'b0);

        // Same target as committed connection
        req_valid = 1'b1; req_tgt = 2'b01;
        tick();
        req_valid = 1'b0;
        check_eq("same_done",  done,  1'b1);
        check_eq("same_drv_a", drv_a, 1'b1);
        check_eq("same_busy",  busy,  1'b0);
        tick();
        check_eq("same_done_clr", done,  1'b0);
        check_eq("same_drv_a2",   drv_a, 1'b1);

        // A -> B; request for OFF held during HOLD must wait for ready
        req_valid = 1'b1; req_tgt = 2'b10;
        tick();
        req_valid = 1'b0;
        check_eq("ab_drv_a_E", drv_a, 1'b0);
        check_eq("ab_drv_b_E", drv_b, 1'b0);
        check_eq("ab_busy_E",  busy,  1'b1);
        for (int k = 1; k <= 28; k++) begin
            tick();
            if (k == 13) begin
                req_valid = 1'b1; req_tgt = 2'b00;
            end else begin
                req_valid = req_valid;
            end
            check_eq("ab_drv_a",  drv_a, 1'b0);
            check_eq("ab_drv_b",  drv_b, (k >= 4) ? 1'b1 : 1'b0);
            check_eq("ab_done",   done,  (k == 12) ? 1'b1 : 1'b0);
            check_eq("ab_conn",   conn,  (k >= 12) ? 2'b10 : 2'b01);
            check_eq("ab_ready",  req_ready, (k >= 28) ? 1'b1 : 1'b0);
        end

        // Held request accepted on the first ready edge: B -> OFF
        tick();
        req_valid = 1'b0;
        check_eq("boff_drv_b_E", drv_b, 1'b0);
        check_eq("boff_busy_E",  busy,  1'b1);
        check_eq("boff_ready_E", req_ready, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_eq("boff_done",  done, (k == 4) ? 1'b1 : 1'b0);
            check_eq("boff_conn",  conn, (k >= 4) ? 2'b00 : 2'b10);
            check_eq("boff_ready", req_ready, (k >= 4) ? 1'b1 : 1'b0);
            check_eq("boff_busy",  busy, (k >= 4) ? 1'b0 : 1'b1);
            check_eq("boff_drv_b", drv_b, 1'b0);
        end

        // OFF requested while already OFF
        req_valid = 1'b1; req_tgt = 2'b00;
        tick();
        req_valid = 1'b0;
        check_eq("offoff_done",  done, 1'b1);
        check_eq("offoff_busy",  busy, 1'b0);
        check_eq("offoff_ready", req_ready, 1'b1);

        // Reset during MAKE of a B close
        req_valid = 1'b1; req_tgt = 2'b10;
        tick();
        req_valid = 1'b0;
        check_eq("rmk_drv_b_E", drv_b, 1'b1);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rmk_drv_b", drv_b, 1'b0);
        check_eq("rmk_conn",  conn,  2'b00);
        check_eq("rmk_busy",  busy,  1'b0);
        check_eq("rmk_ready", req_ready, 1'b1);
        check_eq("rmk_done",  done,  1'b0);
        tick();
        check_eq("rmk_done2", done,  1'b0);

        // Normal sequence after reset
        req_valid = 1'b1; req_tgt = 2'b01;
        tick();
        req_valid = 1'b0;
        check_eq("post_drv_a_E", drv_a, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq("post_drv_a", drv_a, 1'b1);
            check_eq("post_done",  done, (k == 8) ? 1'b1 : 1'b0);
            check_eq("post_conn",  conn, (k >= 8) ? 2'b01 : 2'b00);
        end

        tick();
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
